mdu_iter: RTL and testbench

//   Parametrised iterative multiply/divide unit: the multi-cycle companion to the

---
 rtl/mdu_iter.sv | 197 +++++++++++++++++++
 tb/tb_mdu_iter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one bit per cycle.
// A radix-2 shift-add multiplier and a restoring divider share one 2*XLEN
// accumulator. Operands are reduced to magnitudes on accept; the sign is
// re-applied on the last iteration, which also selects the result half.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   flush_i                abort any operation in flight
//   in_valid_i/in_ready_o  request handshake (ready only in IDLE)
//   op_i, a_i, b_i         funct3 and rs1/rs2 operands, sampled on accept
//   out_valid_o/out_ready_i result handshake, result held until accepted
//   result_o               registered result
//   busy_o                 unit is not idle
module mdu_iter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] result_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  localparam logic [XLEN-1:0]   MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0]   ALL_ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE_2X   = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op;
  logic              neg;      // final result must be negated
  logic [2*XLEN-1:0] acc;      // {high/remainder, low/multiplier-quotient}
  logic [XLEN-1:0]   opb;      // multiplicand / divisor magnitude
  logic [XLEN-1:0]   result;

  logic              a_signed, b_signed, a_neg, b_neg, res_neg;
  logic [XLEN-1:0]   a_abs, b_abs, special_res;
  logic              special, accept;

  logic [XLEN:0]     mul_sum, rem_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub, quo, rem;
  logic [2*XLEN-1:0] acc_step, prod;
  logic [XLEN-1:0]   final_res;

  assign accept      = in_valid_i & (state == IDLE) & ~flush_i;
  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);
  assign result_o    = result;

  // Operand decode: signedness, magnitudes, result sign and bypass cases.
  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (op_i)
      3'd1, 3'd4, 3'd6: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'd2:             a_signed = 1'b1;
      default:          ;
    endcase
    a_neg = a_signed & a_i[XLEN-1];
    b_neg = b_signed & b_i[XLEN-1];
    a_abs = a_neg ? (~a_i + ONE_X) : a_i;
    b_abs = b_neg ? (~b_i + ONE_X) : b_i;
    // Remainder follows the dividend; products and quotients use the xor.
    res_neg = (op_i[2] & op_i[1]) ? a_neg : (a_neg ^ b_neg);
    special     = 1'b0;
    special_res = {XLEN{1'b0}};
    if (op_i[2] && (b_i == {XLEN{1'b0}})) begin
      special     = 1'b1;
      special_res = op_i[1] ? a_i : ALL_ONES;
    end else if (op_i[2] && !op_i[0] && (a_i == MIN_INT) && (b_i == ALL_ONES)) begin
      special     = 1'b1;
      special_res = op_i[1] ? {XLEN{1'b0}} : MIN_INT;
    end else begin
      special     = 1'b0;
      special_res = {XLEN{1'b0}};
    end
  end

  // One iteration of the shared datapath plus final sign fix / half select.
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : {(XLEN+1){1'b0}});
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    div_ge  = (rem_sh >= {1'b0, opb});
    // When the trial subtract succeeds the difference is below the divisor,
    // so the low XLEN bits of the subtraction are exact.
    div_sub = rem_sh[XLEN-1:0] - opb;
    if (op[2]) begin
      if (div_ge) begin
        acc_step = {div_sub, acc[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc[XLEN-1:1]};
    end
    quo  = acc_step[XLEN-1:0];
    rem  = acc_step[2*XLEN-1:XLEN];
    prod = neg ? (~acc_step + ONE_2X) : acc_step;
    if (op[2]) begin
      if (op[1]) begin
        final_res = neg ? (~rem + ONE_X) : rem;
      end else begin
        final_res = neg ? (~quo + ONE_X) : quo;
      end
    end else if (op[1:0] == 2'b00) begin
      final_res = prod[XLEN-1:0];
    end else begin
      final_res = prod[2*XLEN-1:XLEN];
    end
  end

  // Next-state logic; flush overrides everything.
  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state_nxt = special ? DONE : CALC;
          end else begin
            state_nxt = IDLE;
          end
        end
        CALC: begin
          if (cnt == CNT_ONE) begin
            state_nxt = DONE;
          end else begin
            state_nxt = CALC;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            state_nxt = IDLE;
          end else begin
            state_nxt = DONE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State, operand latches, iteration counter and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= {CNT_W{1'b0}};
      op     <= 3'd0;
      neg    <= 1'b0;
      acc    <= {(2*XLEN){1'b0}};
      opb    <= {XLEN{1'b0}};
      result <= {XLEN{1'b0}};
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            op  <= op_i;
            neg <= res_neg;
            cnt <= CNT_W'(XLEN);
            acc <= {{XLEN{1'b0}}, a_abs};
            opb <= b_abs;
            if (special) begin
              result <= special_res;
            end
          end
        end
        CALC: begin
          if (!flush_i) begin
            acc <= acc_step;
            cnt <= cnt - CNT_ONE;
            if (cnt == CNT_ONE) begin
              result <= final_res;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;

  logic        flush16, in_valid16, in_ready16, out_valid16, out_ready16, busy16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, result16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_iter #(.XLEN(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .op_i(op), .a_i(a), .b_i(b), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .busy_o(busy)
  );

  mdu_iter #(.XLEN(16), .CNT_W(5)) dut16 (
    .clk(clk), .rst(rst), .flush_i(flush16), .in_valid_i(in_valid16), .in_ready_o(in_ready16),
    .op_i(op16), .a_i(a16), .b_i(b16), .out_valid_o(out_valid16), .out_ready_i(out_ready16),
    .result_o(result16), .busy_o(busy16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model straight from the RV32M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, ps;
    logic [63:0]        ux, uy, pu;
    logic signed [31:0] x32, y32, r32;
    logic               ovf;
    sx  = {{32{x[31]}}, x};
    sy  = {{32{y[31]}}, y};
    ux  = {32'd0, x};
    uy  = {32'd0, y};
    x32 = x;
    y32 = y;
    ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin pu = ux * uy; return pu[31:0]; end
      3'd1: begin ps = sx * sy; return ps[63:32]; end
      3'd2: begin ps = sx * $signed(uy); return ps[63:32]; end
      3'd3: begin pu = ux * uy; return pu[63:32]; end
      3'd4: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        r32 = x32 / y32; return r32;
      end
      3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 32'd0) return x;
        if (ovf) return 32'd0;
        r32 = x32 % y32; return r32;
      end
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && (y == 32'd0)) return 1;
    if ((f == 3'd4 || f == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one request for one cycle; returns in cycle 1 (#1 after the accept edge).
  task automatic start_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    op = f; a = x; b = y; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Wait for out_valid with a bounded budget; cyc counts from the accept cycle.
  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] f, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] exp, input int lat, input int hold);
    int cyc;
    check({name, "_ready"}, in_ready, 1'b1);
    start_op(f, x, y);
    wait_valid(cyc);
    check({name, "_lat"}, cyc, lat);
    check({name, "_res"}, result, exp);
    repeat (hold) begin @(posedge clk); #1; end
    check({name, "_held"}, out_valid, 1'b1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  vec_t vecs[14];

  initial begin
    int cyc, cnt;
    logic [31:0] held, x, y;
    logic [2:0]  f;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'd4, 32'd12345,      32'd0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1};
    vecs[12] = '{3'd5, 32'd9,          32'd0,         32'hFFFF_FFFF, 1};
    vecs[13] = '{3'd7, 32'd9,          32'd0,         32'd9,         1};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 3'd0; a = 32'd0; b = 32'd0;
    flush16 = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0;
    op16 = 3'd0; a16 = 16'd0; b16 = 16'd0;
    #12 rst = 1'b0;
    @(posedge clk); #1;

    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_result", result, 32'd0);

    for (int i = 0; i < 14; i++)
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);

    // Result held 5 cycles without out_ready; no accept in the releasing DONE cycle.
    start_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    wait_valid(cyc);
    check("hold_lat", cyc, 33);
    held = result;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1'b1);
      check("hold_ready_low", in_ready, 1'b0);
      check("hold_result", result, held);
    end
    check("hold_value", held, 32'hFFFF_FFEB);
    out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd1; b = 32'd1;
    check("done_ready_low", in_ready, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("release_idle", busy, 1'b0);
    check("release_valid", out_valid, 1'b0);
    check("release_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("no_b2b_accept", busy, 1'b0);

    // Flush at cycle 10 of a DIV, with a competing request in the same cycle.
    start_op(3'd4, 32'd1000, 32'd3);
    repeat (9) begin @(posedge clk); #1; end
    check("flush_busy_before", busy, 1'b1);
    flush = 1'b1; in_valid = 1'b1; op = 3'd0; a = 32'd5; b = 32'd5;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle", busy, 1'b0);
    check("flush_ready", in_ready, 1'b1);
    check("flush_valid", out_valid, 1'b0);
    cnt = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid || busy) cnt++;
    end
    check("flush_quiet", cnt, 0);
    do_op("post_flush_mul", 3'd0, 32'd3, 32'd4, 32'd12, 33, 0);

    // Asynchronous reset while a result is waiting in DONE.
    start_op(3'd5, 32'd100, 32'd7);
    wait_valid(cyc);
    check("rst_done_valid", out_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_result", result, 32'd0);
    check("rst_async_busy", busy, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // XLEN=16 instance.
    op16 = 3'd0; a16 = 16'd300; b16 = 16'd200; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'hFFFF; b16 = 16'hFFFF;
    cyc = 1;
    while (!out_valid16 && cyc < 60) begin @(posedge clk); #1; cyc++; end
    check("x16_lat", cyc, 17);
    check("x16_res", result16, 16'hEA60);
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check("x16_idle", busy16, 1'b0);

    // Randomized ops against the reference model.
    for (int i = 0; i < 150; i++) begin
      f = 3'($urandom);
      x = ($urandom_range(0, 9) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0:       y = 32'd0;
        1:       y = 32'hFFFF_FFFF;
        2:       y = 32'($urandom_range(1, 15));
        default: y = 32'($urandom);
      endcase
      do_op($sformatf("rnd%0d_op%0d", i, f), f, x, y, ref_model(f, x, y), ref_lat(f, x, y),
            $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
